// File: rtl/ysyx_22040237_ifu_if.sv
// Fetch-unit bus: imem request/response, decode handoff and execute-side redirect.
// The master side is the fetch unit; the slave side is its surroundings.
interface ysyx_22040237_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, pc, fetch_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, pc, fetch_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem read in flight and hands
// {pc, inst} to decode. Every output is a register or a decode of the state.
module ysyx_22040237_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_22040237_ifu_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VALID, S_FAULT} state_e;

  state_e        r_state, w_state_nxt;
  logic [31:0]   r_pc, w_pc_nxt;
  logic [31:0]   r_inst, w_inst_nxt;
  logic          r_drop, w_drop_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          w_redir, w_misal;

  assign w_redir = bus.redirect_valid;
  assign w_misal = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_drop  <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_drop  <= w_drop_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_drop_nxt  = r_drop;
    w_timer_nxt = r_timer;
    if (r_state != S_FAULT && w_misal) begin
      w_state_nxt = S_FAULT;
      w_pc_nxt    = bus.redirect_pc;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_REQ;
          if (w_redir) w_pc_nxt = bus.redirect_pc;
        end
        S_REQ: begin
          if (w_redir) w_pc_nxt = bus.redirect_pc;
          // A request accepted alongside a redirect fetches the old PC: mark it stale.
          if (bus.imem_req_ready) begin
            w_state_nxt = S_WAIT;
            w_timer_nxt = '0;
            w_drop_nxt  = w_redir;
          end
        end
        S_WAIT: begin
          if (r_timer != '1) w_timer_nxt = r_timer + TW'(1);
          if (w_redir) begin
            w_pc_nxt   = bus.redirect_pc;
            w_drop_nxt = 1'b1;
          end
          // A response landing with a redirect belongs to the old PC, error or not.
          if (bus.imem_resp_valid) begin
            if (r_drop || w_redir) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = S_REQ;
            end else if (bus.imem_resp_err) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_inst_nxt  = bus.imem_resp_data;
              w_state_nxt = S_VALID;
            end
          end else if (r_timer == TLAST) begin
            w_state_nxt = S_FAULT;
          end
        end
        S_VALID: begin
          if (bus.inst_ready) begin
            w_state_nxt = S_REQ;
            w_pc_nxt    = w_redir ? bus.redirect_pc : r_pc + 32'd4;
          end else if (w_redir) begin
            w_state_nxt = S_REQ;
            w_pc_nxt    = bus.redirect_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req_valid = (r_state == S_REQ);
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = (r_state == S_VALID);
  assign bus.inst           = r_inst;
  assign bus.pc             = r_pc;
  assign bus.fetch_fault    = (r_state == S_FAULT);
endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Randomized bench for the fetch unit: a latency-programmable memory plus a
// transaction-level model of the expected PC stream, stale discards and faults.
module tb_ysyx_22040237_ifu;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int          TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22040237_ifu_if bus ();

  ysyx_22040237_ifu #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // knobs for the coming cycle
  logic        k_rst = 1'b1, k_rdy = 1'b0, k_ir = 1'b0, k_redir = 1'b0;
  logic [31:0] k_rpc = '0;
  int          k_lat = 0;
  logic        k_err = 1'b0, k_spur = 1'b0;

  // memory side
  logic        mem_out = 1'b0, mem_err = 1'b0;
  int          mem_cnt = 0, mem_lat = 0;
  logic [31:0] mem_addr = '0;

  // reference model
  logic [31:0] m_pc = RPC;
  logic        m_fault = 1'b0, m_out = 1'b0, m_stale = 1'b0, m_rst_chk = 1'b1;
  int          m_wait = 0;
  logic [31:0] acc_q[$];

  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.imem_resp_err   = 1'b0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0010_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic o_req, o_iv, rv_mem, acc, hit;
    logic [31:0] o_addr, r;
    @(negedge clk);
    o_req  = bus.imem_req_valid;
    o_iv   = bus.inst_valid;
    o_addr = bus.imem_req_addr;
    if (m_rst_chk) begin
      chk("rst_req_valid", o_req, 0);
      chk("rst_req_addr", o_addr, RPC);
      chk("rst_inst_valid", o_iv, 0);
      chk("rst_inst", bus.inst, 0);
    end
    chk("fault", bus.fetch_fault, m_fault);
    if (m_fault) chk("fault_quiet", {30'd0, o_req, o_iv}, 0);
    if (o_req) begin
      chk("req_addr", o_addr, m_pc);
      chk("single_outstanding", mem_out, 0);
    end
    if (o_iv) begin
      chk("pc", bus.pc, m_pc);
      chk("inst", bus.inst, mem_word(m_pc));
      chk("req_while_valid", o_req, 0);
    end
    // drive
    rst                = k_rst;
    bus.imem_req_ready = k_rdy;
    bus.inst_ready     = k_ir;
    bus.redirect_valid = k_redir;
    bus.redirect_pc    = k_rpc;
    rv_mem = mem_out && (mem_cnt == mem_lat);
    r = $urandom;
    if (rv_mem) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mem_addr);
      bus.imem_resp_err   = mem_err;
    end else begin
      bus.imem_resp_valid = !mem_out && k_spur;
      bus.imem_resp_data  = r;
      bus.imem_resp_err   = r[0];
    end
    // memory bookkeeping for the coming edge
    acc = !k_rst && o_req && k_rdy;
    if (k_rst) mem_out = 1'b0;
    else begin
      if (rv_mem) mem_out = 1'b0;
      else if (mem_out) mem_cnt++;
      if (acc) begin
        mem_out = 1'b1; mem_cnt = 0; mem_addr = o_addr; mem_lat = k_lat; mem_err = k_err;
      end
    end
    // model: what the coming edge must do
    m_rst_chk = k_rst;
    if (k_rst) begin
      m_pc = RPC; m_fault = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_wait = 0;
    end else if (!m_fault) begin
      if (k_redir && k_rpc[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_pc    = k_rpc;
      end else begin
        hit = m_out && bus.imem_resp_valid;
        if (hit) begin
          m_out = 1'b0;
          if (!m_stale && !k_redir && bus.imem_resp_err) m_fault = 1'b1;
          m_stale = 1'b0;
        end else if (m_out) begin
          if (m_wait == TMO - 1) m_fault = 1'b1;
          else m_wait++;
        end
        if (acc) begin
          m_out = 1'b1; m_wait = 0; m_stale = k_redir;
          acc_q.push_back(o_addr);
        end
        if (o_iv && k_ir) m_pc = k_redir ? k_rpc : m_pc + 32'd4;
        else if (k_redir) begin
          m_pc = k_rpc;
          if (m_out) m_stale = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    k_rst = 1'b1; step(); k_rst = 1'b0;
  endtask

  task automatic wait_accept(input string tag);
    int sz = acc_q.size();
    int i;
    for (i = 0; i < 20 && acc_q.size() == sz; i++) step();
    if (acc_q.size() == sz) chk(tag, 0, 1);
  endtask

  initial begin
    int sz, n, idx;
    logic [31:0] held, r, wrap_nxt;

    // in-order stream, 1-cycle memory
    do_reset();
    k_rdy = 1'b1; k_ir = 1'b1; k_lat = 0;
    acc_q.delete();
    for (int i = 0; i < 12; i++) step();
    chk("seq0", acc_q.size() > 0 ? acc_q[0] : 32'hx, 32'h8000_0000);
    chk("seq1", acc_q.size() > 1 ? acc_q[1] : 32'hx, 32'h8000_0004);
    chk("seq2", acc_q.size() > 2 ? acc_q[2] : 32'hx, 32'h8000_0008);

    // decode stall: held output, no new request
    k_ir = 1'b0;
    for (int i = 0; i < 20 && !bus.inst_valid; i++) step();
    chk("stall_reached", bus.inst_valid, 1);
    held = bus.pc;
    sz   = acc_q.size();
    for (int i = 0; i < 5; i++) step();
    chk("stall_no_req", acc_q.size(), sz);
    chk("stall_pc", bus.pc, held);
    k_ir = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("after_stall", acc_q.size() > sz ? acc_q[sz] : 32'hx, held + 32'd4);

    // redirect while waiting: the late word must be discarded
    k_lat = 2;
    wait_accept("redir_wait_accept");
    sz = acc_q.size();
    k_redir = 1'b1; k_rpc = 32'h8000_0100; step(); k_redir = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("redir_target", acc_q.size() > sz ? acc_q[sz] : 32'hx, 32'h8000_0100);

    // misaligned redirect: sticky fault until reset
    k_redir = 1'b1; k_rpc = 32'h8000_0102; step(); k_redir = 1'b0;
    step();
    chk("misalign_fault", bus.fetch_fault, 1);
    for (int i = 0; i < 4; i++) step();
    chk("misalign_sticky", bus.fetch_fault, 1);
    do_reset();
    step(); step();
    chk("post_rst_req", bus.imem_req_valid, 1);
    chk("post_rst_addr", bus.imem_req_addr, RPC);

    // timeout: no response ever
    k_lat = 99;
    wait_accept("tmo_accept");
    for (n = 1; n <= 10; n++) begin
      step();
      if (bus.fetch_fault) break;
    end
    chk("timeout_cycles", n - 1, TMO);

    // error response
    do_reset();
    k_lat = 0; k_err = 1'b1;
    wait_accept("err_accept");
    k_err = 1'b0;
    step(); step();
    chk("err_fault", bus.fetch_fault, 1);

    // pc wraps past the top of the address space
    do_reset();
    step();
    acc_q.delete();
    k_redir = 1'b1; k_rpc = 32'hFFFF_FFFC; step(); k_redir = 1'b0;
    for (int i = 0; i < 14; i++) step();
    idx = -1;
    foreach (acc_q[i]) if (idx < 0 && acc_q[i] == 32'hFFFF_FFFC) idx = i;
    wrap_nxt = (idx >= 0 && idx + 1 < acc_q.size()) ? acc_q[idx + 1] : 32'hx;
    chk("wrap_next", wrap_nxt, 32'h0);

    // reset while a fetch is outstanding
    k_lat = 3;
    wait_accept("rst_wait_accept");
    step();
    do_reset();
    k_lat = 0;
    for (int i = 0; i < 8; i++) step();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      k_rst  = m_fault ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
      k_rdy  = $urandom_range(0, 9) < 7;
      k_ir   = $urandom_range(0, 9) < 6;
      k_lat  = $urandom_range(0, 3);
      k_err  = $urandom_range(0, 29) == 0;
      k_spur = $urandom_range(0, 19) == 0;
      k_redir = $urandom_range(0, 19) == 0;
      r = $urandom;
      case ($urandom_range(0, 7))
        0:       k_rpc = {r[31:2], 2'($urandom_range(1, 3))};
        1:       k_rpc = 32'hFFFF_FFF8;
        default: k_rpc = {r[31:2], 2'b00};
      endcase
      step();
    end
    k_rst = 1'b0; k_redir = 1'b0; k_spur = 1'b0; k_err = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
